// File: rtl/tinyml_pkg.sv
// Shared constants for the tinyml accelerator: opcodes and default datapath sizes.
package tinyml_pkg;

    // Opcode of the STORE class that launches the vector store engine.
    localparam logic [3:0] OPC_STORE = 4'h3;

    localparam int TINYML_DATA_WIDTH = 8;
    localparam int TINYML_ADDR_WIDTH = 24;
    localparam int TINYML_MAX_LEN    = 128;
    localparam int TINYML_LEN_WIDTH  = 10;

endpackage

// File: rtl/store_v.sv
// Vector store engine: snapshots a result vector on start and streams it to
// byte-addressed memory one element per accepted write, then pulses done.
module store_v
    import tinyml_pkg::*;
#(
    parameter int DATA_WIDTH = TINYML_DATA_WIDTH,
    parameter int ADDR_WIDTH = TINYML_ADDR_WIDTH,
    parameter int MAX_LEN    = TINYML_MAX_LEN,
    parameter int LEN_WIDTH  = TINYML_LEN_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic        [ADDR_WIDTH-1:0] base_addr,
    input  logic        [LEN_WIDTH-1:0]  length,
    input  logic signed [DATA_WIDTH-1:0] vec_in [MAX_LEN],
    output logic                         mem_we,
    output logic        [ADDR_WIDTH-1:0] mem_addr,
    output logic        [DATA_WIDTH-1:0] mem_wdata,
    input  logic                         mem_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int IDX_WIDTH = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic        [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic        [LEN_WIDTH-1:0]  len_q, len_d;
    logic                         mem_we_q, mem_we_d;
    logic        [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic        [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic signed [DATA_WIDTH-1:0] vec_q [MAX_LEN];

    logic                         vec_load_s;
    logic                         accept_s;
    logic                         last_s;
    logic        [IDX_WIDTH-1:0]  idx_inc_s;

    function automatic logic len_legal(input logic [LEN_WIDTH-1:0] len);
        return (len != {LEN_WIDTH{1'b0}}) && (len <= LEN_WIDTH'(MAX_LEN));
    endfunction

    assign accept_s  = mem_we_q & mem_ready;
    assign idx_inc_s = idx_q + IDX_WIDTH'(1);
    assign last_s    = (LEN_WIDTH'(idx_q) == (len_q - LEN_WIDTH'(1)));

    // Next-state and next-output logic; outputs are computed one cycle ahead so they leave registers.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = {ADDR_WIDTH{1'b0}};
        mem_wdata_d = {DATA_WIDTH{1'b0}};
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        vec_load_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_load_s = 1'b1;
                    len_d      = length;
                    idx_d      = {IDX_WIDTH{1'b0}};
                    if (len_legal(length)) begin
                        // vec_q is only loaded at this edge, so the first byte comes straight from vec_in.
                        state_d     = ST_WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = base_addr;
                        mem_wdata_d = vec_in[0];
                        busy_d      = 1'b1;
                    end else begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WRITE: begin
                if (accept_s) begin
                    if (last_s) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        idx_d       = idx_inc_s;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(1);
                        mem_wdata_d = vec_q[idx_inc_s];
                        busy_d      = 1'b1;
                    end
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                    busy_d      = 1'b1;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDX_WIDTH{1'b0}};
            len_q       <= {LEN_WIDTH{1'b0}};
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q <= {DATA_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Vector snapshot; later changes on vec_in cannot disturb a transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                vec_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (vec_load_s) begin
            vec_q <= vec_in;
        end else begin
            vec_q <= vec_q;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_v.sv
// Directed self-checking bench for store_v: one task per scenario, expected values hand-computed.
module tb_store_v;

    localparam int DW = 8;
    localparam int AW = 24;
    localparam int ML = 128;
    localparam int LW = 10;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic        [AW-1:0] base_addr;
    logic        [LW-1:0] length;
    logic signed [DW-1:0] vec_in [ML];
    logic                 mem_we;
    logic        [AW-1:0] mem_addr;
    logic        [DW-1:0] mem_wdata;
    logic                 mem_ready;
    logic                 busy;
    logic                 done;
    logic                 err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];
    int            wc_q [$];
    int            dc_q [$];
    logic          de_q [$];

    store_v dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .vec_in    (vec_in),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Log every accepted write and every done pulse with the edge number it occurred on.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && mem_we && mem_ready) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
        end
        if (rst_n && done) begin
            dc_q.push_back(cyc);
            de_q.push_back(err);
        end
    end

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); dc_q.delete(); de_q.delete();
    endtask

    // Pulse start for one edge; returns at the falling edge of cycle 1.
    task automatic kick(input logic [AW-1:0] b, input logic [LW-1:0] l);
        @(negedge clk);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 24'h000000 || mem_wdata !== 8'h00 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset got we=%b addr=%h data=%h busy=%b done=%b err=%b want all zero",
                     mem_we, mem_addr, mem_wdata, busy, done, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got we=%b busy=%b done=%b want 0 0 0", mem_we, busy, done);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [3];
        bit to;
        exp_d[0] = 8'h05; exp_d[1] = 8'hFF; exp_d[2] = 8'h7F;
        vec_in[0] = 8'sd5; vec_in[1] = -8'sd1; vec_in[2] = 8'sd127;
        mem_ready = 1'b1;
        clear_log();
        kick(24'h000100, 10'd3);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 24'h000100 || mem_wdata !== 8'h05 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_first got we=%b addr=%h data=%h busy=%b want 1 000100 05 1",
                     mem_we, mem_addr, mem_wdata, busy);
        end
        wait_done(10, to);
        total++;
        if (to || err !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL basic_done got timeout=%0b err=%b busy=%b we=%b want 0 0 0 0", to, err, busy, mem_we);
        end
        repeat (2) @(negedge clk);
        total++;
        if (wa_q.size() != 3) begin
            bad++;
            $display("FAIL basic_count got %0d writes want 3", wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wa_q[i] !== 24'h000100 + 24'(i) || wd_q[i] !== exp_d[i] || wc_q[i] - start_cyc != i + 1) begin
                    bad++;
                    $display("FAIL basic_byte%0d got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                             i, wa_q[i], wd_q[i], wc_q[i] - start_cyc, 24'h000100 + 24'(i), exp_d[i], i + 1);
                end
            end
        end
        total++;
        if (dc_q.size() != 1 || dc_q[0] - start_cyc != 4 || de_q[0] !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_cycle got pulses=%0d cyc=%0d want 1 pulse at cycle 4 err 0",
                     dc_q.size(), (dc_q.size() > 0) ? dc_q[0] - start_cyc : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [3];
        int hold_bad;
        exp_d[0] = 8'h05; exp_d[1] = 8'hFF; exp_d[2] = 8'h7F;
        vec_in[0] = 8'sd5; vec_in[1] = -8'sd1; vec_in[2] = 8'sd127;
        mem_ready = 1'b0;
        hold_bad  = 0;
        clear_log();
        kick(24'h000100, 10'd3);
        for (int c = 0; c < 9; c++) begin
            if (mem_we !== 1'b1 || mem_addr !== 24'h000100 + 24'(c / 3) || mem_wdata !== exp_d[c / 3]) begin
                hold_bad++;
            end
            mem_ready = (c % 3 == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL bp_hold got %0d unstable cycles want 0", hold_bad);
        end
        total++;
        if (done !== 1'b1 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL bp_done got done=%b we=%b at cycle 10 want 1 0", done, mem_we);
        end
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (wa_q.size() != 3 || dc_q.size() != 1) begin
            bad++;
            $display("FAIL bp_count got writes=%0d dones=%0d want 3 1", wa_q.size(), dc_q.size());
        end else begin
            total++;
            if (wd_q[0] !== 8'h05 || wd_q[1] !== 8'hFF || wd_q[2] !== 8'h7F || wc_q[2] - start_cyc != 9) begin
                bad++;
                $display("FAIL bp_order got %h %h %h last=%0d want 05 ff 7f last=9",
                         wd_q[0], wd_q[1], wd_q[2], wc_q[2] - start_cyc);
            end
        end
    endtask

    task automatic test_illegal();
        logic [LW-1:0] lens [2];
        lens[0] = 10'd0; lens[1] = 10'd129;
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            clear_log();
            kick(24'h000300, lens[k]);
            total++;
            if (done !== 1'b1 || err !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL illegal_len%0d got done=%b err=%b we=%b busy=%b want 1 1 0 0",
                         lens[k], done, err, mem_we, busy);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || err !== 1'b0 || mem_we !== 1'b0) begin
                bad++;
                $display("FAIL illegal_after%0d got done=%b err=%b we=%b want 0 0 0", lens[k], done, err, mem_we);
            end
            @(negedge clk);
            total++;
            if (wa_q.size() != 0 || dc_q.size() != 1) begin
                bad++;
                $display("FAIL illegal_log%0d got writes=%0d dones=%0d want 0 1", lens[k], wa_q.size(), dc_q.size());
            end
        end
    endtask

    task automatic test_wrap_full();
        logic [AW-1:0] exp_a [4];
        bit to;
        int mis;
        exp_a[0] = 24'hFFFFFE; exp_a[1] = 24'hFFFFFF; exp_a[2] = 24'h000000; exp_a[3] = 24'h000001;
        for (int i = 0; i < 4; i++) vec_in[i] = 8'(8'h11 * (i + 1));
        mem_ready = 1'b1;
        clear_log();
        kick(24'hFFFFFE, 10'd4);
        wait_done(20, to);
        repeat (2) @(negedge clk);
        total++;
        if (to || wa_q.size() != 4) begin
            bad++;
            $display("FAIL wrap_count got timeout=%0b writes=%0d want 0 4", to, wa_q.size());
        end else begin
            mis = 0;
            for (int i = 0; i < 4; i++) begin
                if (wa_q[i] !== exp_a[i] || wd_q[i] !== 8'(8'h11 * (i + 1))) mis++;
            end
            total++;
            if (mis != 0) begin
                bad++;
                $display("FAIL wrap_addr got %h %h %h %h want fffffe ffffff 000000 000001",
                         wa_q[0], wa_q[1], wa_q[2], wa_q[3]);
            end
        end

        for (int i = 0; i < ML; i++) vec_in[i] = 8'(i * 7 + 3);
        clear_log();
        kick(24'h001000, 10'd128);
        wait_done(200, to);
        repeat (2) @(negedge clk);
        total++;
        if (to || wa_q.size() != 128) begin
            bad++;
            $display("FAIL full_count got timeout=%0b writes=%0d want 0 128", to, wa_q.size());
        end else begin
            mis = 0;
            for (int i = 0; i < ML; i++) begin
                if (wa_q[i] !== 24'h001000 + 24'(i) || wd_q[i] !== 8'(i * 7 + 3) || wc_q[i] - start_cyc != i + 1) mis++;
            end
            total++;
            if (mis != 0) begin
                bad++;
                $display("FAIL full_data got %0d wrong bytes want 0", mis);
            end
        end
        total++;
        if (dc_q.size() != 1 || dc_q[0] - start_cyc != 129) begin
            bad++;
            $display("FAIL full_done got pulses=%0d cyc=%0d want 1 at 129",
                     dc_q.size(), (dc_q.size() > 0) ? dc_q[0] - start_cyc : -1);
        end
    endtask

    task automatic test_ignored_start();
        bit to;
        int mis;
        for (int i = 0; i < 5; i++) vec_in[i] = 8'(8'h40 + i);
        mem_ready = 1'b1;
        clear_log();
        kick(24'h000200, 10'd5);
        start     = 1'b1;
        base_addr = 24'h000900;
        length    = 10'd2;
        for (int i = 0; i < ML; i++) vec_in[i] = 8'sh99;
        @(negedge clk);
        start = 1'b0;
        wait_done(20, to);
        start  = 1'b1;
        length = 10'd3;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (to || mem_we !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL start_on_done got timeout=%0b we=%b busy=%b want 0 0 0", to, mem_we, busy);
        end
        repeat (3) @(negedge clk);
        mis = 0;
        if (wa_q.size() != 5) begin
            mis = 99;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (wa_q[i] !== 24'h000200 + 24'(i) || wd_q[i] !== 8'(8'h40 + i)) mis++;
            end
        end
        total++;
        if (mis != 0 || dc_q.size() != 1) begin
            bad++;
            $display("FAIL ignored_start got writes=%0d wrong=%0d dones=%0d want 5 0 1", wa_q.size(), mis, dc_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int s1;
        vec_in[0] = 8'sh0A; vec_in[1] = 8'sh0B;
        mem_ready = 1'b1;
        clear_log();
        kick(24'h000400, 10'd2);
        s1 = start_cyc;
        wait_done(10, to);
        kick(24'h000500, 10'd2);
        total++;
        if (to || mem_we !== 1'b1 || mem_addr !== 24'h000500 || start_cyc - s1 != 4) begin
            bad++;
            $display("FAIL b2b_restart got timeout=%0b we=%b addr=%h gap=%0d want 0 1 000500 4",
                     to, mem_we, mem_addr, start_cyc - s1);
        end
        wait_done(10, to);
        repeat (2) @(negedge clk);
        total++;
        if (to || wa_q.size() != 4 || dc_q.size() != 2) begin
            bad++;
            $display("FAIL b2b_count got timeout=%0b writes=%0d dones=%0d want 0 4 2", to, wa_q.size(), dc_q.size());
        end else begin
            total++;
            if (wa_q[2] !== 24'h000500 || wd_q[3] !== 8'h0B || wc_q[2] - start_cyc != 1) begin
                bad++;
                $display("FAIL b2b_second got addr=%h data=%h cyc=%0d want 000500 0b 1",
                         wa_q[2], wd_q[3], wc_q[2] - start_cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int mis;
        for (int i = 0; i < 5; i++) vec_in[i] = 8'(8'hA0 + i);
        mem_ready = 1'b1;
        clear_log();
        kick(24'h000600, 10'd5);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 24'h000000 || mem_wdata !== 8'h00 ||
            busy !== 1'b0 || done !== 1'b0 || wa_q.size() != 2) begin
            bad++;
            $display("FAIL mid_reset got we=%b addr=%h data=%h busy=%b done=%b writes=%0d want 0 0 0 0 0 2",
                     mem_we, mem_addr, mem_wdata, busy, done, wa_q.size());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (wa_q.size() != 2 || dc_q.size() != 0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_quiet got writes=%0d dones=%0d we=%b want 2 0 0", wa_q.size(), dc_q.size(), mem_we);
        end
        clear_log();
        kick(24'h000700, 10'd5);
        wait_done(20, to);
        repeat (2) @(negedge clk);
        mis = 0;
        if (wa_q.size() != 5) begin
            mis = 99;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (wa_q[i] !== 24'h000700 + 24'(i) || wd_q[i] !== 8'(8'hA0 + i)) mis++;
            end
        end
        total++;
        if (to || mis != 0 || dc_q.size() != 1 || dc_q[0] - start_cyc != 6) begin
            bad++;
            $display("FAIL post_reset_xfer got timeout=%0b writes=%0d wrong=%0d dones=%0d want 0 5 0 1 at 6",
                     to, wa_q.size(), mis, dc_q.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        mem_ready = 1'b1;
        base_addr = 24'h000000;
        length    = 10'd0;
        for (int i = 0; i < ML; i++) vec_in[i] = 8'sh00;
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal();
        test_wrap_full();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
